// File: rtl/serial_compare_ctrl_if.sv
// Bundles the operand handshake, the 1-bit comparator slice link and the
// result outputs of serial_compare_ctrl into a single interface.
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(WIDTH);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             slice_a;
  logic             slice_b;
  logic             slice_eq;
  logic             slice_gt;
  logic             slice_lt;
  logic [IW-1:0]    bit_idx;
  logic             busy;
  logic             done;
  logic             AeqB;
  logic             AgtB;
  logic             AltB;
  logic             err;

  // Requester side: supplies operands and hosts the external comparator slice.
  modport master (
    output start_valid, a_in, b_in, slice_eq, slice_gt, slice_lt,
    input  start_ready, slice_a, slice_b, bit_idx, busy, done,
           AeqB, AgtB, AltB, err
  );

  // Controller side.
  modport slave (
    input  start_valid, a_in, b_in, slice_eq, slice_gt, slice_lt,
    output start_ready, slice_a, slice_b, bit_idx, busy, done,
           AeqB, AgtB, AltB, err
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// MSB-first serial magnitude comparator controller that time-shares one
// external 1-bit comparator slice across a WIDTH-bit operand pair.
module serial_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  serial_compare_ctrl_if.slave  bus
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             eq_r;
  logic             gt_r;
  logic             lt_r;
  logic             err_r;
  logic             vgt_r;
  logic             vlt_r;

  logic             slice_a_s;
  logic             slice_b_s;
  logic             onehot_s;
  logic             last_s;
  logic             sticky_gt_s;
  logic             sticky_lt_s;
  logic             fin_s;
  logic             res_eq_s;
  logic             res_gt_s;
  logic             res_lt_s;
  logic             res_err_s;

  function automatic logic is_one_hot3(input logic [2:0] v);
    logic r;
    case (v)
      3'b001, 3'b010, 3'b100: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Slice drive and per-bit decision logic.
  always_comb begin
    slice_a_s   = 1'b0;
    slice_b_s   = 1'b0;
    fin_s       = 1'b0;
    res_eq_s    = 1'b0;
    res_gt_s    = 1'b0;
    res_lt_s    = 1'b0;
    res_err_s   = 1'b0;
    onehot_s    = is_one_hot3({bus.slice_eq, bus.slice_gt, bus.slice_lt});
    last_s      = (idx_r == {IW{1'b0}});
    // The first differing bit wins; later bits cannot overturn it.
    sticky_gt_s = vgt_r | (~vlt_r & bus.slice_gt);
    sticky_lt_s = vlt_r | (~vgt_r & bus.slice_lt);

    if (state_r == COMPARE) begin
      slice_a_s = a_r[idx_r];
      slice_b_s = b_r[idx_r];
    end else begin
      slice_a_s = 1'b0;
      slice_b_s = 1'b0;
    end

    if (!onehot_s) begin
      fin_s     = 1'b1;
      res_err_s = 1'b1;
    end else if (EARLY_EXIT) begin
      if (bus.slice_gt) begin
        fin_s    = 1'b1;
        res_gt_s = 1'b1;
      end else if (bus.slice_lt) begin
        fin_s    = 1'b1;
        res_lt_s = 1'b1;
      end else if (last_s) begin
        fin_s    = 1'b1;
        res_eq_s = 1'b1;
      end else begin
        fin_s    = 1'b0;
      end
    end else begin
      if (last_s) begin
        fin_s    = 1'b1;
        res_gt_s = sticky_gt_s;
        res_lt_s = sticky_lt_s;
        res_eq_s = ~sticky_gt_s & ~sticky_lt_s;
      end else begin
        fin_s    = 1'b0;
      end
    end
  end

  // Controller FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      idx_r   <= {IW{1'b0}};
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      eq_r    <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      err_r   <= 1'b0;
      vgt_r   <= 1'b0;
      vlt_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start_valid) begin
            a_r     <= bus.a_in;
            b_r     <= bus.b_in;
            idx_r   <= IW'(WIDTH - 1);
            vgt_r   <= 1'b0;
            vlt_r   <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= COMPARE;
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        COMPARE: begin
          if (fin_s) begin
            eq_r    <= res_eq_s;
            gt_r    <= res_gt_s;
            lt_r    <= res_lt_s;
            err_r   <= res_err_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r - IW'(1);
            vgt_r   <= sticky_gt_s;
            vlt_r   <= sticky_lt_s;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready = ready_r;
  assign bus.slice_a     = slice_a_s;
  assign bus.slice_b     = slice_b_s;
  assign bus.bit_idx     = idx_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.AeqB        = eq_r;
  assign bus.AgtB        = gt_r;
  assign bus.AltB        = lt_r;
  assign bus.err         = err_r;
endmodule
